case_6_mul_share_arb: RTL and testbench
=======================================

# case_6_mul_share_arb

Round-robin arbiter and sequencer that shares one 12-bit-signed × 5-bit-signed multiplier, truncated to 14 bits, among `NUM_REQ` independent requesters. Each requester has a valid/ready operand channel and a valid/ready result channel, and may have at most one operation outstanding. The block sits between kernel lanes and the single `case_6_mul_12s_5s_14_1_1` instance (combinational, `NUM_STAGE=0`). It adds one operand register stage and one result register per requester.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `A_WIDTH`, default 12: signed operand A width.
- `B_WIDTH`, default 5: signed operand B width.
- `P_WIDTH`, default 14: result width, the low bits of the full product.
- `ap_clk`  in  1  single clock; all state on the rising edge.
- `ap_rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  operand valid, one bit per requester.
- `req_ready`  out  NUM_REQ  operand accepted this cycle; one-hot or zero.
- `req_a`  in  NUM_REQ*A_WIDTH  packed operand A; requester i occupies bits [i*A_WIDTH +: A_WIDTH].
- `req_b`  in  NUM_REQ*B_WIDTH  packed operand B, packed the same way.
- `rsp_valid`  out  NUM_REQ  result valid per requester.
- `rsp_ready`  in  NUM_REQ  result consumed per requester.
- `rsp_data`  out  NUM_REQ*P_WIDTH  packed signed results.
- `busy`  out  1  high when any pending bit is set.

## Operation
- **State**
  - `pending[NUM_REQ]`: set on operand acceptance, cleared on result handshake (`rsp_valid[i] & rsp_ready[i]`).
  - `rr_ptr`: index of the last granted requester.
  - Stage-1 register: `s1_valid`, `s1_id`, `s1_a`, `s1_b`.
  - Per-requester `rsp_valid` and `rsp_data` registers.
- **Eligibility:** requester i is eligible when `req_valid[i]` is high and `pending[i]` is 0. `pending` is registered, so requester i can be re-granted no earlier than the cycle after its result is popped.
- **Arbitration** (combinational)
  - Search starts at `(rr_ptr+1) mod NUM_REQ` and increments with wrap; the first eligible requester is granted.
  - `req_ready[grant]` = 1; all other `req_ready` bits are 0.
  - `req_ready` does not depend on `rsp_ready` in the same cycle.
- **On acceptance at an edge**
  - `s1_valid` ← 1; `s1_id` ← grant; `s1_a`, `s1_b` ← granted operands.
  - `pending[grant]` ← 1; `rr_ptr` ← grant.
- **With no acceptance:** `s1_valid` ← 0; `rr_ptr` holds.
- **Multiply**
  - The multiplier is driven from `s1_a`/`s1_b` only.
  - The full signed product is `A_WIDTH+B_WIDTH` = 17 bits. `rsp_data[s1_id]` takes product[P_WIDTH-1:0]: wrap, no saturation.
  - Stage-1 output is written at the edge after acceptance, with `rsp_valid[s1_id]` ← 1.
- **Result hold:** `rsp_valid[i]` and `rsp_data[i]` hold until the handshake. On handshake, `rsp_valid[i]` ← 0 and `pending[i]` ← 0.
- **No overwrite:** a result write never targets a slot with `rsp_valid` high, because `pending` guarantees this.
- **Simultaneous events:** a result write for requester i and a pop of requester j≠i in the same cycle are independent.
- **Changing inputs:** a requester that drops `req_valid` before a grant is legal. Operands are sampled only on the grant edge.

## Timing
- **Reset** (`ap_rst_n` low, asynchronous, any time)
  - `pending`=0, `s1_valid`=0, `rsp_valid`=0, `rsp_data`=0, `rr_ptr`=NUM_REQ-1, `busy`=0.
  - `req_ready` is forced to 0 while reset is asserted.
  - In-flight operations are discarded with no result.
- **Latency:** operand handshake at edge k → `rsp_valid` high after edge k+1, i.e. 2 cycles.
- **Throughput:**
  - Aggregate: 1 operation per cycle when at least one requester is eligible.
  - Per requester: 1 operation per 3 cycles when `rsp_ready` is held high (accept k, result k+1, pop k+2, re-grant k+3).
- **Fairness:** a continuously eligible requester waits at most NUM_REQ-1 grants.
- **First grant after reset:** requester 0 has highest priority.

## Test plan
- **Single op, requester 0:** a=−3, b=7 → `req_ready[0]` high in the same cycle; `rsp_data[0]`=14'h3FEB (−21) 2 cycles later.
- **Truncation:**
  - a=2047, b=15 → 14'h37F1 (−2063).
  - a=−2048, b=−16 → 14'h0000.
  - a=−2048, b=1 → 14'h3800.
- **Round-robin:** all 4 requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0,… with no grant skipped while eligible; aggregate 1 grant/cycle.
- **Back-pressure:**
  - Requester 2 holds `rsp_ready`=0 for 10 cycles → `rsp_data[2]` stable, `req_ready[2]`=0 throughout, other requesters continue.
  - After the pop, requester 2 is re-granted one cycle later.
- **Mid-operation reset:** assert `ap_rst_n`=0 one cycle after accepting an operand from requester 1 → all `rsp_valid`=0, `busy`=0 immediately. After release, requester 0 wins a simultaneous 0/1 request.
- **Random soak:** 10k random operands, random valid/ready on all requesters → every result equals the reference (a*b) mod 2^14 and arrives in order per requester; `req_ready` is never multi-hot.

Source files
------------

// File: rtl/case_6_mul_share_arb.sv
// Round-robin sharing of one combinational signed multiplier among NUM_REQ
// requesters. Each requester has one operand channel and one result slot.
// Only one operation per requester may be in flight. A registered pending
// bit blocks a re-grant until that requester's result has been popped.

// Combinational signed multiplier. The output keeps only the low P_WIDTH
// bits of the full product, so large products wrap.
module case_6_mul_12s_5s_14_1_1 #(
    parameter int A_WIDTH = 12,
    parameter int B_WIDTH = 5,
    parameter int P_WIDTH = 14
) (
    input  logic [A_WIDTH-1:0] din0,
    input  logic [B_WIDTH-1:0] din1,
    output logic [P_WIDTH-1:0] dout
);
    localparam int F_WIDTH = A_WIDTH + B_WIDTH;

    logic signed [F_WIDTH-1:0] a_ext_s;
    logic signed [F_WIDTH-1:0] b_ext_s;
    logic signed [F_WIDTH-1:0] full_s;

    assign a_ext_s = $signed({{B_WIDTH{din0[A_WIDTH-1]}}, din0});
    assign b_ext_s = $signed({{A_WIDTH{din1[B_WIDTH-1]}}, din1});
    assign full_s  = a_ext_s * b_ext_s;
    assign dout    = full_s[P_WIDTH-1:0];
endmodule

module case_6_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int A_WIDTH = 12,
    parameter int B_WIDTH = 5,
    parameter int P_WIDTH = 14
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [NUM_REQ*P_WIDTH-1:0] rsp_data,
    output logic                       busy
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]         pending_r;
    logic [NUM_REQ-1:0]         pending_next_s;
    logic [ID_W-1:0]            rr_ptr_r;
    logic                       busy_r;
    logic                       s1_valid_r;
    logic [ID_W-1:0]            s1_id_r;
    logic [A_WIDTH-1:0]         s1_a_r;
    logic [B_WIDTH-1:0]         s1_b_r;
    logic [NUM_REQ-1:0]         rsp_valid_r;
    logic [NUM_REQ*P_WIDTH-1:0] rsp_data_r;

    logic [NUM_REQ-1:0]         eligible_s;
    logic [NUM_REQ-1:0]         pop_s;
    logic [NUM_REQ-1:0]         grant_mask_s;
    logic                       grant_found_s;
    logic [ID_W-1:0]            grant_id_s;
    int                         idx_s;
    logic [A_WIDTH-1:0]         sel_a_s;
    logic [B_WIDTH-1:0]         sel_b_s;
    logic [P_WIDTH-1:0]         prod_s;

    assign eligible_s = req_valid & ~pending_r;
    assign pop_s      = rsp_valid_r & rsp_ready;

    // Round-robin search. It starts one past the last grant and wraps at NUM_REQ.
    always_comb begin
        grant_found_s = 1'b0;
        grant_id_s    = '0;
        grant_mask_s  = '0;
        idx_s         = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx_s = int'(rr_ptr_r) + off;
            if (idx_s >= NUM_REQ) begin
                idx_s = idx_s - NUM_REQ;
            end else begin
                idx_s = idx_s;
            end
            if (!grant_found_s && eligible_s[idx_s]) begin
                grant_found_s       = 1'b1;
                grant_id_s          = idx_s[ID_W-1:0];
                grant_mask_s[idx_s] = 1'b1;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Operand ready is the one-hot grant. It is held low while reset is asserted.
    always_comb begin
        if (ap_rst_n) begin
            req_ready = grant_mask_s;
        end else begin
            req_ready = '0;
        end
    end

    // Select the granted requester's operands for the stage-1 register.
    always_comb begin
        sel_a_s = req_a[int'(grant_id_s)*A_WIDTH +: A_WIDTH];
        sel_b_s = req_b[int'(grant_id_s)*B_WIDTH +: B_WIDTH];
    end

    // Next pending value. A grant sets the bit and a result pop clears it.
    // Both cannot happen to one slot in the same cycle.
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_mask_s[i]) begin
                pending_next_s[i] = 1'b1;
            end else if (pop_s[i]) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
        end
    end

    // Arbitration state and the operand register stage.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pending_r  <= '0;
            busy_r     <= 1'b0;
            rr_ptr_r   <= ID_W'(NUM_REQ - 1);
            s1_valid_r <= 1'b0;
            s1_id_r    <= '0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
        end else begin
            pending_r  <= pending_next_s;
            busy_r     <= |pending_next_s;
            s1_valid_r <= grant_found_s;
            if (grant_found_s) begin
                rr_ptr_r <= grant_id_s;
                s1_id_r  <= grant_id_s;
                s1_a_r   <= sel_a_s;
                s1_b_r   <= sel_b_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    case_6_mul_12s_5s_14_1_1 #(
        .A_WIDTH(A_WIDTH),
        .B_WIDTH(B_WIDTH),
        .P_WIDTH(P_WIDTH)
    ) u_mul (
        .din0(s1_a_r),
        .din1(s1_b_r),
        .dout(prod_s)
    );

    // Per-requester result slots. A slot is written from stage 1 and held until popped.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (s1_valid_r && (int'(s1_id_r) == i)) begin
                    rsp_valid_r[i]                    <= 1'b1;
                    rsp_data_r[i*P_WIDTH +: P_WIDTH] <= prod_s;
                end else if (pop_s[i]) begin
                    rsp_valid_r[i] <= 1'b0;
                end else begin
                    rsp_valid_r[i] <= rsp_valid_r[i];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;
endmodule

// File: tb/tb_case_6_mul_share_arb.sv
// Directed and random checks for the shared-multiplier round-robin arbiter.
module tb_case_6_mul_share_arb;
    logic        clk = 1'b0;
    logic        ap_rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [47:0] req_a;
    logic [19:0] req_b;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [55:0] rsp_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0] exp_d [4];
    logic        exp_v [4];

    case_6_mul_share_arb dut (
        .ap_clk(clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [13:0] ref_mul(input logic [11:0] a, input logic [4:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[13:0];
    endfunction

    task automatic set_op(input int r, input logic [11:0] a, input logic [4:0] b);
        req_a[r*12 +: 12] = a;
        req_b[r*5 +: 5]   = b;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        ap_rst_n = 1'b0;
        #1;
        ap_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 4'h0; req_a = 48'h0; req_b = 20'h0;
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 4'h0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rsp_data !== 56'h0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        req_valid = 4'h0; ap_rst_n = 1'b1;
        step(); #1;
        n_cmp++; if (rsp_valid !== 4'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_idle: got valid %b busy %b want 0000 0", rsp_valid, busy); end
    endtask

    task automatic test_single();
        set_op(0, 12'hFFD, 5'h07); req_valid = 4'b0001; #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        step(); req_valid = 4'h0; #1;
        n_cmp++; if (rsp_valid !== 4'h0) begin n_bad++; $display("FAIL single_early: got %b want 0000", rsp_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        step(); #1;
        n_cmp++; if (rsp_valid !== 4'b0001) begin n_bad++; $display("FAIL single_valid: got %b want 0001", rsp_valid); end
        n_cmp++; if (rsp_data[13:0] !== 14'h3FEB) begin n_bad++; $display("FAIL single_data: got %h want 3feb", rsp_data[13:0]); end
        rsp_ready = 4'b0001;
        step(); rsp_ready = 4'h0; #1;
        n_cmp++; if (rsp_valid !== 4'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL single_pop: got valid %b busy %b want 0000 0", rsp_valid, busy); end
    endtask

    task automatic test_truncation();
        logic [11:0] ta [3];
        logic [4:0]  tb [3];
        logic [13:0] tp [3];
        logic [3:0]  m;
        int r;
        ta[0] = 12'h7FF; tb[0] = 5'h0F; tp[0] = 14'h37F1;
        ta[1] = 12'h800; tb[1] = 5'h10; tp[1] = 14'h0000;
        ta[2] = 12'h800; tb[2] = 5'h01; tp[2] = 14'h3800;
        for (int v = 0; v < 3; v++) begin
            r = v + 1;
            m = 4'b0001 << r;
            set_op(r, ta[v], tb[v]); req_valid = m; #1;
            n_cmp++; if (req_ready !== m) begin n_bad++; $display("FAIL trunc_ready[%0d]: got %b want %b", v, req_ready, m); end
            step(); req_valid = 4'h0;
            step(); #1;
            n_cmp++; if (rsp_valid !== m) begin n_bad++; $display("FAIL trunc_valid[%0d]: got %b want %b", v, rsp_valid, m); end
            n_cmp++; if (rsp_data[r*14 +: 14] !== tp[v]) begin n_bad++; $display("FAIL trunc_data[%0d]: got %h want %h", v, rsp_data[r*14 +: 14], tp[v]); end
            rsp_ready = m;
            step(); rsp_ready = 4'h0;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] m;
        pulse_reset();
        for (int i = 0; i < 4; i++) set_op(i, 12'(i + 5), 5'(i + 1));
        req_valid = 4'hF; rsp_ready = 4'hF;
        for (int c = 0; c < 16; c++) begin
            #1;
            m = 4'b0001 << (c % 4);
            n_cmp++; if (req_ready !== m) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, m); end
            step();
        end
        req_valid = 4'h0;
        for (int c = 0; c < 4; c++) step();
        #1;
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 4'h0) begin n_bad++; $display("FAIL rr_drain: got busy %b valid %b want 0 0000", busy, rsp_valid); end
        rsp_ready = 4'h0;
    endtask

    task automatic test_back_pressure();
        pulse_reset();
        set_op(0, 12'h011, 5'h02); set_op(1, 12'h022, 5'h03);
        set_op(2, 12'h123, 5'h1D); set_op(3, 12'h044, 5'h04);
        req_valid = 4'hF; rsp_ready = 4'b1011;
        for (int c = 0; c < 4; c++) step();
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++; if (rsp_valid[2] !== 1'b1) begin n_bad++; $display("FAIL bp_valid2[%0d]: got %b want 1", c, rsp_valid[2]); end
            n_cmp++; if (rsp_data[41:28] !== 14'h3C97) begin n_bad++; $display("FAIL bp_data2[%0d]: got %h want 3c97", c, rsp_data[41:28]); end
            n_cmp++; if (req_ready[2] !== 1'b0) begin n_bad++; $display("FAIL bp_ready2[%0d]: got %b want 0", c, req_ready[2]); end
            n_cmp++; if (req_ready === 4'h0) begin n_bad++; $display("FAIL bp_others[%0d]: got %b want a grant", c, req_ready); end
            step();
        end
        req_valid = 4'b0100; rsp_ready = 4'hF; #1;
        n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL bp_pop_cycle: got %b want 0000", req_ready); end
        step(); #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_regrant: got %b want 0100", req_ready); end
        step(); req_valid = 4'h0;
        for (int c = 0; c < 4; c++) step();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got %b want 0", busy); end
        rsp_ready = 4'h0;
    endtask

    task automatic test_mid_reset();
        set_op(1, 12'h055, 5'h03); req_valid = 4'b0010;
        step();
        req_valid = 4'b0011; ap_rst_n = 1'b0; #1;
        n_cmp++; if (rsp_valid !== 4'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_clear: got valid %b busy %b want 0000 0", rsp_valid, busy); end
        n_cmp++; if (req_ready !== 4'h0) begin n_bad++; $display("FAIL mid_reset_ready: got %b want 0000", req_ready); end
        step();
        ap_rst_n = 1'b1; set_op(0, 12'h004, 5'h02); #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_reset_prio: got %b want 0001", req_ready); end
        step(); req_valid = 4'h0;
        step(); #1;
        n_cmp++; if (rsp_valid !== 4'b0001 || rsp_data[13:0] !== 14'h0008) begin n_bad++; $display("FAIL mid_reset_result: got valid %b data %h want 0001 0008", rsp_valid, rsp_data[13:0]); end
        rsp_ready = 4'hF;
        step(); rsp_ready = 4'h0; #1;
        n_cmp++; if (rsp_valid !== 4'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_drain: got valid %b busy %b want 0000 0", rsp_valid, busy); end
    endtask

    task automatic test_soak();
        int accepted = 0;
        int cyc = 0;
        int tail = 0;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin exp_v[i] = 1'b0; exp_d[i] = 14'h0; end
        while (cyc < 60000 && tail < 6) begin
            if (accepted < 10000) begin
                req_valid = 4'($urandom);
                rsp_ready = 4'($urandom);
            end else begin
                req_valid = 4'h0;
                rsp_ready = 4'hF;
                tail++;
            end
            req_a = {16'($urandom), 32'($urandom)};
            req_b = 20'($urandom);
            #1;
            n_cmp++;
            if ($countones(req_ready) > 1 || (req_ready & ~req_valid) !== 4'h0) begin
                n_bad++; $display("FAIL soak_ready[%0d]: got %b with valid %b", cyc, req_ready, req_valid);
            end
            for (int i = 0; i < 4; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    n_cmp++;
                    if (!exp_v[i] || rsp_data[i*14 +: 14] !== exp_d[i]) begin
                        n_bad++; $display("FAIL soak_result[%0d] req %0d: got %h want %h (expected pending %b)", cyc, i, rsp_data[i*14 +: 14], exp_d[i], exp_v[i]);
                    end
                    exp_v[i] = 1'b0;
                end
                if (req_ready[i]) begin
                    n_cmp++;
                    if (exp_v[i]) begin n_bad++; $display("FAIL soak_regrant[%0d] req %0d: got grant want none while outstanding", cyc, i); end
                    exp_d[i] = ref_mul(req_a[i*12 +: 12], req_b[i*5 +: 5]);
                    exp_v[i] = 1'b1;
                    accepted++;
                end
            end
            step();
            cyc++;
        end
        n_cmp++; if (accepted < 10000) begin n_bad++; $display("FAIL soak_budget: got %0d accepted want 10000", accepted); end
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (exp_v[i]) begin n_bad++; $display("FAIL soak_lost req %0d: got no result want %h", i, exp_d[i]); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL soak_busy: got %b want 0", busy); end
        rsp_ready = 4'h0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_truncation();
        test_round_robin();
        test_back_pressure();
        test_mid_reset();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
